debounce_edge_detect: RTL and testbench

DEBOUNCE_EDGE_DETECT -- requirements
Module: debounce_edge_detect

---
 rtl/debounce_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/debounce_edge_detect.sv | 111 +++++++++++
 tb/tb_debounce_edge_detect.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/edge-detect block: FSM encoding and
// default qualification parameters.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

   localparam int STABLE_CYCLES_DEF = 5;
   localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops
// clear to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/debounce_edge_detect.sv
// Debouncer with edge pulses: a level change on D is accepted only after it
// has been seen on STABLE_CYCLES+1 consecutive synchronized samples.
//
// state       | meaning
// ------------+-----------------------------------------------
// S_LOW       | accepted level 0, input agrees
// S_WAIT_HIGH | accepted level 0, input high, qualifying rise
// S_HIGH      | accepted level 1, input agrees
// S_WAIT_LOW  | accepted level 1, input low, qualifying fall
module debounce_edge_detect
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic D,
   output logic Q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             d_s;
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             q_nx, rise_nx, fall_nx, busy_nx;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (D),
      .q     (d_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_LOW;
         cnt   <= '0;
         Q     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         Q     <= q_nx;
         rise  <= rise_nx;
         fall  <= fall_nx;
         busy  <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      q_nx     = Q;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
         S_LOW: begin
            if (d_s) begin
               state_nx = S_WAIT_HIGH;
               cnt_nx   = '0;
            end
         end
         S_WAIT_HIGH: begin
            if (!d_s) begin
               state_nx = S_LOW;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = S_HIGH;
               cnt_nx   = '0;
               q_nx     = 1'b1;
               rise_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!d_s) begin
               state_nx = S_WAIT_LOW;
               cnt_nx   = '0;
            end
         end
         S_WAIT_LOW: begin
            if (d_s) begin
               state_nx = S_HIGH;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = S_LOW;
               cnt_nx   = '0;
               q_nx     = 1'b0;
               fall_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = S_LOW;
            cnt_nx   = '0;
         end
      endcase
      // busy is registered from the next state so it tracks the wait states exactly
      busy_nx = (state_nx == S_WAIT_HIGH) || (state_nx == S_WAIT_LOW);
   end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect with a run-length reference model
// checked every cycle, plus hand-computed latency and pulse-count checks.
module tb_debounce_edge_detect;
   import debounce_pkg::*;

   localparam int S = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic D = 1'b0;
   logic Q, rise, fall, busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rise_n = 0;
   int fall_n = 0;

   debounce_edge_detect #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .D     (D),
      .Q     (Q),
      .rise  (rise),
      .fall  (fall),
      .busy  (busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: the synchronized input lags D by two edges; the accepted
   // level flips once S+1 consecutive synchronized samples disagree with it.
   bit s1, s2, ds;
   bit mq, mrise, mfall, mbusy;
   int run;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 = 0; s2 = 0; mq = 0; mrise = 0; mfall = 0; mbusy = 0; run = 0;
      end else begin
         ds = s2;
         s2 = s1;
         s1 = D;
         mrise = 0;
         mfall = 0;
         if (ds != mq) run++;
         else run = 0;
         if (run == S + 1) begin
            mq = ds;
            mrise = ds;
            mfall = !ds;
            run = 0;
         end
         mbusy = (run > 0);
      end
   end

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      chk("Q", Q, mq);
      chk("rise", rise, mrise);
      chk("fall", fall, mfall);
      chk("busy", busy, mbusy);
      if (rise && fall) chk("rise_and_fall", 1, 0);
      if (rise) rise_n++;
      if (fall) fall_n++;
   end

   // Waits up to budget negedges for a rise (want_rise=1) or fall pulse;
   // returns the cycle it was seen (-1 if never) and busy cycles before it.
   task automatic wait_pulse(input bit want_rise, input int budget, output int at, output int nbusy);
      at = -1;
      nbusy = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (want_rise ? rise : fall) begin
            at = cyc;
            break;
         end
         if (busy) nbusy++;
      end
   endtask

   int c, at, nb, r0, f0;

   initial begin
      // reset held with D toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         D = ~D;
      end
      chk("reset_rise_n", rise_n, 0);
      chk("reset_fall_n", fall_n, 0);
      @(negedge clk);
      D = 1'b0;
      #5 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_state", 32'(dut.state), 32'(S_LOW));
      chk("post_reset_Q", Q, 0);

      // clean rise
      @(negedge clk);
      D = 1'b1;
      c = cyc;
      wait_pulse(1, 20, at, nb);
      chk("rise_latency", at, c + 8);
      chk("rise_busy_cycles", nb, 5);
      repeat (4) @(negedge clk);
      chk("rise_count", rise_n, 1);
      chk("rise_Q", Q, 1);

      // clean fall
      @(negedge clk);
      D = 1'b0;
      c = cyc;
      wait_pulse(0, 20, at, nb);
      chk("fall_latency", at, c + 8);
      chk("fall_busy_cycles", nb, 5);
      repeat (4) @(negedge clk);
      chk("fall_count", fall_n, 1);
      chk("fall_rise_count", rise_n, 1);

      // glitch: 5 sampled edges high is one short of acceptance
      nb = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         D = (i < 5);
         if (busy) nb++;
      end
      chk("glitch_rise_count", rise_n, 1);
      chk("glitch_Q", Q, 0);
      chk("glitch_busy", busy, 0);
      chk("glitch_busy_cycles", nb, 5);

      // 6 sampled edges high is just enough
      r0 = rise_n;
      @(negedge clk);
      D = 1'b1;
      c = cyc;
      repeat (6) @(negedge clk);
      D = 1'b0;
      wait_pulse(1, 10, at, nb);
      chk("min_pulse_rise_at", at, c + 8);
      wait_pulse(0, 20, at, nb);
      chk("min_pulse_fall_seen", (at > 0), 1);
      chk("min_pulse_rise_count", rise_n, r0 + 1);

      // bounce: toggle every 2 cycles, final transition to 1 is held
      repeat (3) @(negedge clk);
      r0 = rise_n;
      f0 = fall_n;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         D = ((i % 4) < 2);
         if (i == 8) c = cyc;
      end
      wait_pulse(1, 20, at, nb);
      chk("bounce_rise_at", at, c + 8);
      repeat (5) @(negedge clk);
      chk("bounce_rise_count", rise_n, r0 + 1);
      chk("bounce_fall_count", fall_n, f0);

      // return low before the reset test
      D = 1'b0;
      wait_pulse(0, 20, at, nb);
      chk("bounce_return_low", Q, 0);
      repeat (2) @(negedge clk);

      // reset during qualification
      r0 = rise_n;
      f0 = fall_n;
      @(negedge clk);
      D = 1'b1;
      repeat (6) @(negedge clk);
      chk("midq_cnt_before", 32'(dut.cnt), 3);
      chk("midq_busy_before", busy, 1);
      #5 reset = 1'b1;
      #1;
      chk("midq_busy_clr", busy, 0);
      chk("midq_Q_clr", Q, 0);
      chk("midq_cnt_clr", 32'(dut.cnt), 0);
      repeat (2) @(negedge clk);
      chk("midq_no_pulse", rise_n, r0);
      #5 reset = 1'b0;
      c = cyc;
      wait_pulse(1, 20, at, nb);
      chk("midq_rise_at", at, c + 8);
      repeat (3) @(negedge clk);
      chk("midq_rise_count", rise_n, r0 + 1);
      chk("midq_fall_count", fall_n, f0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
